// File: rtl/conveng_pkg.sv
// Shared types and helpers for the convolution-engine input path.
// Holds the FSM state encoding, skid depth, per-beat flags and config check.
package conveng_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam int SKID_DEPTH = 2;

  typedef struct packed {
    logic last_x;
    logic last_y;
  } beat_flags_t;

  // nl is a power of two, so the remainder test reduces to a low-bit mask
  function automatic logic cfg_ok(input logic [31:0] width, input logic [31:0] height,
                                  input int nl);
    logic [31:0] w_mask;
    w_mask = 32'(nl - 1);
    return (width != '0) && (height != '0) && ((width & w_mask) == '0);
  endfunction

endpackage

// File: rtl/inpinf_skid.sv
// 2-entry FIFO-ordered skid buffer: a push shows at the output the next cycle.
// o_not_full depends only on registered occupancy, so upstream ready never sees i_pop_rdy.
module inpinf_skid
  import conveng_pkg::*;
#(
  parameter int W = 10
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_push_dat,
  input  logic         i_push_vld,
  output logic         o_not_full,
  output logic [W-1:0] o_pop_dat,
  output logic         o_pop_vld,
  input  logic         i_pop_rdy
);

  logic [W-1:0] r_mem [SKID_DEPTH];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_occ;
  logic         w_push;
  logic         w_pop;

  assign o_not_full = (r_occ < 2'(SKID_DEPTH));
  assign o_pop_vld  = (r_occ != 2'd0);
  assign o_pop_dat  = r_mem[r_rd_ptr];
  assign w_push     = i_push_vld && o_not_full;
  assign w_pop      = o_pop_vld && i_pop_rdy;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_occ <= r_occ + 2'(w_push) - 2'(w_pop);
    end
  end

endmodule

// File: rtl/inpinf_mc.sv
// Pixel input stage: per-frame armed, tags NL-lane beats with last_x/last_y; 1-cycle accept-to-output latency.
// px_in_ready comes from registered state and skid occupancy only. INPINF_MC_XY_EN adds px_out_x/px_out_y.
module inpinf_mc
  import conveng_pkg::*;
#(
  parameter int XB = 10,
  parameter int YB = 10,
  parameter int PB = 8,
  parameter int NL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XB-1:0]    cfg_width,
  input  logic [YB-1:0]    cfg_height,
  input  logic             cfg_start,
  input  logic [NL*PB-1:0] px_in_data,
  input  logic             px_in_valid,
  output logic             px_in_ready,
  output logic [NL*PB-1:0] px_out_data,
  output logic             px_out_valid,
  input  logic             px_out_ready,
  output logic             px_out_last_x,
  output logic             px_out_last_y,
  output logic [XB-1:0]    col_count,
  output logic [YB-1:0]    row_count,
  output logic             busy,
  output logic             done,
  output logic             err_cfg
`ifdef INPINF_MC_XY_EN
  ,
  output logic [XB-1:0]    px_out_x,
  output logic [YB-1:0]    px_out_y
`endif
);

  localparam int DW = NL * PB;
`ifdef INPINF_MC_XY_EN
  localparam int PW = DW + 2 + XB + YB;
`else
  localparam int PW = DW + 2;
`endif

  state_t        r_state;
  logic [XB-1:0] r_width;
  logic [YB-1:0] r_height;
  logic [XB-1:0] r_col;
  logic [YB-1:0] r_row;
  logic          r_done;
  logic          r_err;

  logic          w_not_full;
  logic          w_in_rdy;
  logic          w_acc;
  logic          w_cfg_ok;
  logic          w_pop_vld;
  logic          w_pop_hs;
  logic [PW-1:0] w_push_dat;
  logic [PW-1:0] w_pop_dat;
  beat_flags_t   w_in_flags;
  beat_flags_t   w_out_flags;

  assign w_in_rdy          = (r_state == RUN) && w_not_full;
  assign w_acc             = px_in_valid && w_in_rdy;
  assign w_cfg_ok          = cfg_ok(32'(cfg_width), 32'(cfg_height), NL);
  assign w_in_flags.last_x = (r_col == r_width - XB'(NL));
  assign w_in_flags.last_y = (r_row == r_height - YB'(1));
  assign w_pop_hs          = w_pop_vld && px_out_ready;

`ifdef INPINF_MC_XY_EN
  assign w_push_dat = {r_row, r_col, w_in_flags, px_in_data};
  assign px_out_x   = w_pop_dat[DW+2 +: XB];
  assign px_out_y   = w_pop_dat[DW+2+XB +: YB];
`else
  assign w_push_dat = {w_in_flags, px_in_data};
`endif
  assign w_out_flags = beat_flags_t'(w_pop_dat[DW +: 2]);

  inpinf_skid #(.W(PW)) u_skid (
    .i_clk      (clk),
    .i_rst_n    (rst),
    .i_push_dat (w_push_dat),
    .i_push_vld (w_acc),
    .o_not_full (w_not_full),
    .o_pop_dat  (w_pop_dat),
    .o_pop_vld  (w_pop_vld),
    .i_pop_rdy  (px_out_ready)
  );

  // Counts keep their post-final-beat values (col 0, row height) until the next arm
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_width  <= '0;
      r_height <= '0;
      r_col    <= '0;
      r_row    <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cfg_start) begin
            if (w_cfg_ok) begin
              r_state  <= RUN;
              r_width  <= cfg_width;
              r_height <= cfg_height;
              r_col    <= '0;
              r_row    <= '0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (w_acc) begin
            if (w_in_flags.last_x) begin
              r_col <= '0;
              r_row <= r_row + YB'(1);
            end else begin
              r_col <= r_col + XB'(NL);
            end
            if (w_in_flags.last_x && w_in_flags.last_y) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_pop_hs && w_out_flags.last_x && w_out_flags.last_y) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign px_in_ready   = w_in_rdy;
  assign px_out_data   = w_pop_dat[DW-1:0];
  assign px_out_valid  = w_pop_vld;
  assign px_out_last_x = w_out_flags.last_x;
  assign px_out_last_y = w_out_flags.last_y;
  assign col_count     = r_col;
  assign row_count     = r_row;
  assign busy          = (r_state != IDLE);
  assign done          = r_done;
  assign err_cfg       = r_err;

endmodule

// File: tb/tb_inpinf_mc.sv
// Scoreboard bench for inpinf_mc: one NL=1 instance and one NL=4 instance on a shared clock/reset.
`timescale 1ns/1ps
module tb_inpinf_mc;

  localparam int XB = 10;
  localparam int YB = 10;
  localparam int PB = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] dat;
    logic        lx;
    logic        ly;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];

  // NL=1 instance
  logic [XB-1:0] c1_w = '0;
  logic [YB-1:0] c1_h = '0;
  logic          c1_start = 1'b0;
  logic [7:0]    c1_in = '0;
  logic          c1_vld = 1'b0;
  logic          c1_ordy = 1'b1;
  logic          tog1 = 1'b0;
  logic          o1_irdy, o1_vld, o1_lx, o1_ly, o1_busy, o1_done, o1_err;
  logic [7:0]    o1_dat;
  logic [XB-1:0] o1_col;
  logic [YB-1:0] o1_row;

  // NL=4 instance
  logic [XB-1:0] c4_w = '0;
  logic [YB-1:0] c4_h = '0;
  logic          c4_start = 1'b0;
  logic [31:0]   c4_in = '0;
  logic          c4_vld = 1'b0;
  logic          c4_ordy = 1'b1;
  logic          o4_irdy, o4_vld, o4_lx, o4_ly, o4_busy, o4_done, o4_err;
  logic [31:0]   o4_dat;
  logic [XB-1:0] o4_col;
  logic [YB-1:0] o4_row;

  inpinf_mc #(.XB(XB), .YB(YB), .PB(PB), .NL(1)) u1 (
    .clk(clk), .rst(rst),
    .cfg_width(c1_w), .cfg_height(c1_h), .cfg_start(c1_start),
    .px_in_data(c1_in), .px_in_valid(c1_vld), .px_in_ready(o1_irdy),
    .px_out_data(o1_dat), .px_out_valid(o1_vld), .px_out_ready(c1_ordy),
    .px_out_last_x(o1_lx), .px_out_last_y(o1_ly),
    .col_count(o1_col), .row_count(o1_row),
    .busy(o1_busy), .done(o1_done), .err_cfg(o1_err)
  );

  inpinf_mc #(.XB(XB), .YB(YB), .PB(PB), .NL(4)) u4 (
    .clk(clk), .rst(rst),
    .cfg_width(c4_w), .cfg_height(c4_h), .cfg_start(c4_start),
    .px_in_data(c4_in), .px_in_valid(c4_vld), .px_in_ready(o4_irdy),
    .px_out_data(o4_dat), .px_out_valid(o4_vld), .px_out_ready(c4_ordy),
    .px_out_last_x(o4_lx), .px_out_last_y(o4_ly),
    .col_count(o4_col), .row_count(o4_row),
    .busy(o4_busy), .done(o4_done), .err_cfg(o4_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Output-ready pattern for u1: steady 1, or toggling every cycle
  initial forever begin
    @(posedge clk); #1;
    c1_ordy = tog1 ? ~c1_ordy : 1'b1;
  end

  // Bench-side occupancy of u1's buffer, counted at the handshaking edges
  int acc1 = 0;
  int pop1 = 0;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc1 <= 0;
      pop1 <= 0;
    end else begin
      if (c1_vld && o1_irdy) acc1 <= acc1 + 1;
      if (o1_vld && c1_ordy) pop1 <= pop1 + 1;
    end
  end

  logic       pend1 = 1'b0;
  logic       stall1 = 1'b0;
  logic [9:0] last1 = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      pend1  = 1'b0;
      stall1 = 1'b0;
    end else begin
      if (acc1 - pop1 == 2) chk("u1_full_in_ready", 32'(o1_irdy), 0);
      if (stall1) begin
        chk("u1_stall_valid", 32'(o1_vld), 1);
        chk("u1_stall_stable", 32'({o1_dat, o1_lx, o1_ly}), 32'(last1));
      end
      stall1 = o1_vld && !c1_ordy;
      last1  = {o1_dat, o1_lx, o1_ly};
      if (pend1) begin
        chk("u1_done", 32'(o1_done), 1);
        pend1 = 1'b0;
      end else if (o1_done) begin
        chk("u1_done_spurious", 32'(o1_done), 0);
      end
      if (o1_vld && c1_ordy) begin
        if (q1.size() == 0) begin
          chk("u1_pop_empty_queue", 32'(q1.size()), 1);
        end else begin
          e = q1.pop_front();
          chk("u1_data", 32'(o1_dat), e.dat);
          chk("u1_last_x", 32'(o1_lx), 32'(e.lx));
          chk("u1_last_y", 32'(o1_ly), 32'(e.ly));
        end
        if (o1_lx && o1_ly) pend1 = 1'b1;
      end
    end
  end

  logic pend4 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      pend4 = 1'b0;
    end else begin
      if (pend4) begin
        chk("u4_done", 32'(o4_done), 1);
        pend4 = 1'b0;
      end else if (o4_done) begin
        chk("u4_done_spurious", 32'(o4_done), 0);
      end
      if (o4_vld && c4_ordy) begin
        if (q4.size() == 0) begin
          chk("u4_pop_empty_queue", 32'(q4.size()), 1);
        end else begin
          e = q4.pop_front();
          chk("u4_data", o4_dat, e.dat);
          chk("u4_last_x", 32'(o4_lx), 32'(e.lx));
          chk("u4_last_y", 32'(o4_ly), 32'(e.ly));
        end
        if (o4_lx && o4_ly) pend4 = 1'b1;
      end
    end
  end

  // All tasks are entered and left at #1 after a rising edge
  task automatic start1(input int w, input int h, input logic exp_err);
    c1_w = XB'(w); c1_h = YB'(h); c1_start = 1'b1;
    @(posedge clk); #1;
    c1_start = 1'b0;
    chk("u1_arm_err", 32'(o1_err), 32'(exp_err));
    chk("u1_arm_busy", 32'(o1_busy), 32'(!exp_err));
  endtask

  task automatic drive1(input int w, input int h, input bit gaps, input int base,
                        input int maxb);
    int k = 0;
    int budget = 0;
    while (k < maxb && budget < 400) begin
      c1_vld = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      c1_in  = 8'(base + k);
      @(negedge clk);
      if (c1_vld && o1_irdy) begin
        chk("u1_col_count", 32'(o1_col), 32'(k % w));
        chk("u1_row_count", 32'(o1_row), 32'(k / w));
        q1.push_back('{dat: 32'(base + k), lx: ((k % w) == w - 1), ly: ((k / w) == h - 1)});
        k++;
      end
      @(posedge clk); #1;
      budget++;
    end
    c1_vld = 1'b0;
    if (k < maxb) chk("u1_drive_timeout", 32'(k), 32'(maxb));
  endtask

  task automatic wait_idle1(input string nm);
    int n = 0;
    while (o1_busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    chk(nm, 32'(o1_busy), 0);
    chk("u1_queue_drained", 32'(q1.size()), 0);
  endtask

  task automatic drive4(input int nb);
    int b = 0;
    int budget = 0;
    while (b < nb && budget < 100) begin
      c4_vld = 1'b1;
      c4_in  = 32'h03020100 + 32'(b) * 32'h04040404;
      @(negedge clk);
      if (o4_irdy) begin
        chk("u4_col_count", 32'(o4_col), 32'((b % 2) * 4));
        chk("u4_row_count", 32'(o4_row), 32'(b / 2));
        q4.push_back('{dat: c4_in, lx: ((b % 2) == 1), ly: (b >= 2)});
        b++;
      end
      @(posedge clk); #1;
      budget++;
    end
    c4_vld = 1'b0;
    if (b < nb) chk("u4_drive_timeout", 32'(b), 32'(nb));
  endtask

  task automatic bad_cfg4(input int w, input int h);
    c4_w = XB'(w); c4_h = YB'(h); c4_start = 1'b1;
    @(posedge clk); #1;
    c4_start = 1'b0;
    chk("u4_err_pulse", 32'(o4_err), 1);
    chk("u4_err_busy", 32'(o4_busy), 0);
    chk("u4_err_in_ready", 32'(o4_irdy), 0);
    @(posedge clk); #1;
    chk("u4_err_one_cycle", 32'(o4_err), 0);
    chk("u4_err_in_ready2", 32'(o4_irdy), 0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(o1_irdy), 0);
    chk("rst_out_valid", 32'(o1_vld), 0);
    chk("rst_out_data", 32'(o1_dat), 0);
    chk("rst_busy", 32'(o1_busy), 0);
    chk("rst_flags", 32'({o1_lx, o1_ly, o1_done, o1_err}), 0);
    chk("rst_counts", 32'({o1_col, o1_row}), 0);
    chk("rst_u4_out", o4_dat, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // NL=1 4x3, continuous
    start1(4, 3, 1'b0);
    drive1(4, 3, 1'b0, 1, 12);
    wait_idle1("t1_busy_after");

    // NL=4 8x2
    c4_w = 10'd8; c4_h = 10'd2; c4_start = 1'b1;
    @(posedge clk); #1;
    c4_start = 1'b0;
    chk("u4_arm_busy", 32'(o4_busy), 1);
    drive4(4);
    n = 0;
    while (o4_busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    chk("t2_busy_after", 32'(o4_busy), 0);
    chk("t2_row_final", 32'(o4_row), 2);
    chk("t2_col_final", 32'(o4_col), 0);
    chk("t2_queue_drained", 32'(q4.size()), 0);

    // 4x3 with input gaps and toggling output ready
    tog1 = 1'b1;
    start1(4, 3, 1'b0);
    drive1(4, 3, 1'b1, 16, 12);
    wait_idle1("t3_busy_after");
    tog1 = 1'b0;

    // Rejected configs on NL=4
    bad_cfg4(6, 2);
    bad_cfg4(8, 0);

    // cfg_start mid-frame with a different geometry is ignored
    start1(4, 3, 1'b0);
    fork
      drive1(4, 3, 1'b0, 32, 12);
      begin
        repeat (4) @(posedge clk);
        #1;
        c1_w = 10'd2; c1_h = 10'd2; c1_start = 1'b1;
        @(posedge clk); #1;
        c1_start = 1'b0;
        chk("t5_no_err", 32'(o1_err), 0);
        chk("t5_still_busy", 32'(o1_busy), 1);
      end
    join
    wait_idle1("t5_busy_after");
    chk("t5_row_final", 32'(o1_row), 3);

    // Reset after beat 5, then a fresh 2x2 frame
    start1(4, 3, 1'b0);
    drive1(4, 3, 1'b0, 64, 5);
    rst = 1'b0;
    #1;
    chk("t6_rst_in_ready", 32'(o1_irdy), 0);
    chk("t6_rst_out_valid", 32'(o1_vld), 0);
    chk("t6_rst_out_data", 32'(o1_dat), 0);
    chk("t6_rst_busy", 32'(o1_busy), 0);
    chk("t6_rst_counts", 32'({o1_col, o1_row}), 0);
    q1.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_no_done", 32'(o1_done), 0);
    start1(2, 2, 1'b0);
    drive1(2, 2, 1'b0, 128, 4);
    wait_idle1("t6_busy_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog simulation did not complete, checks=%0d", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
